// File: rtl/imem_loader.sv
// imem_loader: writable instruction memory for the basic processor.
// A host streams a length word, the data words and an XOR checksum word
// over a valid/ready handshake. The processor keeps a combinational read
// port, which returns zero while a load holds the processor stalled.
module imem_loader #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic                   ld_valid,
    input  logic [WORD_W-1:0]      ld_data,
    output logic                   ld_ready,
    output logic                   cpu_hold,
    output logic                   load_ok,
    output logic                   load_err,
    input  logic [WORD_W-OP_W-1:0] Iaddress,
    output logic [WORD_W-1:0]      Idata
);

    localparam int A_W   = WORD_W - OP_W;
    localparam int DEPTH = 2 ** A_W;

    // A length field of zero stands for a full-depth load, which needs the
    // extra bit of the remaining-word counter.
    localparam logic [A_W:0]   FULL_LEN  = {1'b1, {A_W{1'b0}}};
    localparam logic [A_W:0]   REM_ONE   = {{A_W{1'b0}}, 1'b1};
    localparam logic [A_W-1:0] WPTR_ONE  = {{(A_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEN   = 2'd1,
        DATA  = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t             state_q;
    logic [A_W-1:0]     wptr_q;
    logic [A_W:0]       remaining_q;
    logic [WORD_W-1:0]  csum_q;
    logic               load_ok_q;
    logic               load_err_q;
    logic [WORD_W-1:0]  mem_q [DEPTH];

    logic               xfer;
    logic               memWrite;

    // The loader is ready in every state except IDLE, so ready and hold are
    // both straight decodes of the registered state.
    assign ld_ready = (state_q != IDLE);
    assign cpu_hold = (state_q != IDLE);
    assign xfer     = ld_valid && ld_ready;

    // A restart request wins over a simultaneous word, so that word is dropped.
    assign memWrite = xfer && !load_start && (state_q == DATA);

    assign load_ok  = load_ok_q;
    assign load_err = load_err_q;

    // While a load is in progress the processor sees the same all-zero word
    // an unprogrammed ROM location would return.
    assign Idata = cpu_hold ? '0 : mem_q[Iaddress];

    // Session sequencer: framing, write pointer, running checksum and flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            remaining_q <= '0;
            csum_q      <= '0;
            load_ok_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else if (load_start) begin
            state_q    <= LEN;
            wptr_q     <= '0;
            csum_q     <= '0;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else if (xfer) begin
            case (state_q)
                LEN: begin
                    if (ld_data[A_W-1:0] == '0) begin
                        remaining_q <= FULL_LEN;
                    end else begin
                        remaining_q <= {1'b0, ld_data[A_W-1:0]};
                    end
                    state_q <= DATA;
                end
                DATA: begin
                    csum_q      <= csum_q ^ ld_data;
                    wptr_q      <= wptr_q + WPTR_ONE;
                    remaining_q <= remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (ld_data == csum_q) begin
                        load_ok_q <= 1'b1;
                    end else begin
                        load_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Instruction storage; reset clears every word so an unloaded memory reads zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWrite) begin
            mem_q[wptr_q] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed and random load sessions checked
// against a word-level model of the load protocol and a flag scoreboard.
`timescale 1ns/100ps
module tb_imem_loader;

   localparam int WORD_W = 8;
   localparam int OP_W   = 3;
   localparam int A_W    = WORD_W - OP_W;
   localparam int DEPTH  = 2 ** A_W;

   logic             clock = 1'b0;
   logic             reset;
   logic             loadStart;
   logic             ldValid;
   logic [WORD_W-1:0] ldData;
   logic             ldReady;
   logic             cpuHold;
   logic             loadOk;
   logic             loadErr;
   logic [A_W-1:0]   iAddress;
   logic [WORD_W-1:0] iData;

   imem_loader #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .load_start(loadStart),
      .ld_valid  (ldValid),
      .ld_data   (ldData),
      .ld_ready  (ldReady),
      .cpu_hold  (cpuHold),
      .load_ok   (loadOk),
      .load_err  (loadErr),
      .Iaddress  (iAddress),
      .Idata     (iData)
   );

   // Free-running 100 MHz clock.
   always #5 clock = ~clock;

   typedef struct packed {
      bit ok;
      bit err;
   } flags_t;

   int        checks = 0;
   int        errors = 0;
   flags_t    expQ[$];
   bit        abortPending = 1'b0;
   bit        prevHold = 1'b0;

   logic [7:0] modelMem [DEPTH];
   bit         modelOk;
   bit         modelErr;
   bit         sessActive;
   int         sessCount;
   int         sessLen;
   logic [7:0] sessCsum;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: a fresh session discards whatever the previous one had framed.
   function automatic void modelStart();
      modelOk    = 1'b0;
      modelErr   = 1'b0;
      sessActive = 1'b1;
      sessCount  = 0;
      sessLen    = 0;
      sessCsum   = 8'h00;
   endfunction

   // Model: interpret the n-th word of a session as length, data or checksum.
   function automatic void modelWord(input logic [7:0] w);
      flags_t f;
      if (!sessActive) return;
      if (sessCount == 0) begin
         sessLen = (w % DEPTH == 0) ? DEPTH : int'(w % DEPTH);
      end else if (sessCount <= sessLen) begin
         modelMem[sessCount - 1] = w;
         sessCsum = sessCsum ^ w;
      end else begin
         f.ok  = (w == sessCsum);
         f.err = (w != sessCsum);
         modelOk  = f.ok;
         modelErr = f.err;
         expQ.push_back(f);
         sessActive = 1'b0;
      end
      sessCount++;
   endfunction

   // Monitor: each fall of cpu_hold outside a reset ends a session, whose
   // flags are compared with the oldest expected result.
   always @(negedge clock) begin
      flags_t e;
      if (prevHold && !cpuHold) begin
         if (abortPending) begin
            abortPending = 1'b0;
         end else if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL holdDrop actual=unexpected session end expected=none at %0t", $time);
         end else begin
            e = expQ.pop_front();
            checkOutput("okFlag", int'(loadOk), int'(e.ok));
            checkOutput("errFlag", int'(loadErr), int'(e.err));
         end
      end
      prevHold = cpuHold;
   end

   // Pulse load_start from the current negedge; whatever ldValid holds is left alone.
   task automatic applyStimulusStart();
      loadStart = 1'b1;
      modelStart();
      @(negedge clock);
      loadStart = 1'b0;
      checkOutput("holdRise", int'({cpuHold, ldReady}), 3);
      checkOutput("flagsClear", int'({loadOk, loadErr}), 0);
      checkOutput("idataHeld", int'(iData), 0);
   endtask

   // Present one word after a random idle gap; it is accepted on the next edge.
   task automatic applyStimulusWord(input logic [7:0] w, input int maxGap);
      int gap;
      gap = $urandom_range(0, maxGap);
      if (gap > 0) begin
         ldValid = 1'b0;
         repeat (gap) @(negedge clock);
      end
      ldValid = 1'b1;
      ldData  = w;
      checkOutput("readyHigh", int'(ldReady), 1);
      modelWord(w);
      @(negedge clock);
   endtask

   // Finish a session: hold must already be down, then drain the scoreboard.
   task automatic applyStimulusEnd();
      int budget;
      ldValid = 1'b0;
      checkOutput("holdFall", int'(cpuHold), 0);
      budget = 5;
      while (expQ.size() != 0 && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL sessionResult actual=missing expected=%0d results at %0t", expQ.size(), $time);
         expQ.delete();
      end
   endtask

   // Sweep every address and confirm memory contents and sticky flags.
   task automatic checkMemory();
      for (int a = 0; a < DEPTH; a++) begin
         iAddress = a[A_W-1:0];
         #1;
         checkOutput($sformatf("idata[%0d]", a), int'(iData), int'(modelMem[a]));
         @(negedge clock);
      end
      checkOutput("okSticky", int'(loadOk), int'(modelOk));
      checkOutput("errSticky", int'(loadErr), int'(modelErr));
      checkOutput("idleReady", int'({cpuHold, ldReady}), 0);
   endtask

   // Full session with a given length byte, data and checksum.
   task automatic runSession(input logic [7:0] lenByte, input logic [7:0] data[$],
                             input logic [7:0] csum, input int maxGap);
      applyStimulusStart();
      applyStimulusWord(lenByte, maxGap);
      foreach (data[i]) applyStimulusWord(data[i], maxGap);
      applyStimulusWord(csum, maxGap);
      applyStimulusEnd();
   endtask

   // Main sequence: directed cases from the load protocol, then random sessions.
   initial begin
      logic [7:0] d[$];
      logic [7:0] c;
      logic [7:0] lb;
      int         n;

      reset     = 1'b1;
      loadStart = 1'b0;
      ldValid   = 1'b0;
      ldData    = 8'h00;
      iAddress  = '0;
      for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'h00;
      modelOk    = 1'b0;
      modelErr   = 1'b0;
      sessActive = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      $display("[TB] reset and idle sweep");
      checkMemory();

      $display("[TB] good load, back-to-back");
      d = '{8'h41, 8'h22, 8'h07};
      runSession(8'h03, d, 8'h64, 0);
      checkMemory();

      $display("[TB] bad checksum with gaps");
      runSession(8'h03, d, 8'h65, 3);
      checkMemory();

      $display("[TB] full-depth load");
      d.delete();
      for (int i = 0; i < DEPTH; i++) d.push_back(8'(i + 1));
      runSession(8'h00, d, 8'h20, 0);
      checkOutput("fullOk", int'(loadOk), 1);
      checkMemory();

      $display("[TB] restart mid-load");
      applyStimulusStart();
      applyStimulusWord(8'h04, 0);
      applyStimulusWord(8'hAA, 0);
      applyStimulusWord(8'hBB, 0);
      applyStimulusStart();
      d = '{8'h11};
      applyStimulusWord(8'h01, 1);
      applyStimulusWord(8'h11, 1);
      applyStimulusWord(8'h11, 1);
      applyStimulusEnd();
      checkOutput("restartOk", int'(loadOk), 1);
      checkMemory();

      $display("[TB] random sessions");
      for (int s = 0; s < 6; s++) begin
         lb = 8'($urandom_range(0, 255));
         n  = (lb % DEPTH == 0) ? DEPTH : int'(lb % DEPTH);
         d.delete();
         c = 8'h00;
         for (int i = 0; i < n; i++) begin
            d.push_back(8'($urandom_range(0, 255)));
            c = c ^ d[i];
         end
         if ($urandom_range(0, 1) == 1) c = c ^ 8'($urandom_range(1, 255));
         iAddress = A_W'($urandom_range(0, DEPTH - 1));
         runSession(lb, d, c, 3);
         checkMemory();
      end

      $display("[TB] reset mid-load");
      applyStimulusStart();
      applyStimulusWord(8'h05, 0);
      applyStimulusWord(8'h5A, 0);
      applyStimulusWord(8'hC3, 0);
      ldValid = 1'b0;
      abortPending = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rstHoldReady", int'({cpuHold, ldReady}), 0);
      checkOutput("rstFlags", int'({loadOk, loadErr}), 0);
      for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'h00;
      modelOk    = 1'b0;
      modelErr   = 1'b0;
      sessActive = 1'b0;
      expQ.delete();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkMemory();

      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory for the basic processor. It replaces the fixed program ROM with a 2^(WORD_W-OP_W)-word RAM that a host loads over a valid/ready byte stream. The processor-side read port stays combinational, and `cpu_hold` keeps the processor stalled while a load is in progress. Each load is framed as a length word, then the data words, then an XOR checksum word, and ends with a sticky pass/fail flag.

## Interface
Parameters:
- `WORD_W`, 8, instruction/data word width
- `OP_W`, 3, opcode field width; address width `A_W = WORD_W-OP_W` (5), depth `2**A_W` (32)

Ports:
- `clock`  in  1  single system clock, rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `load_start`  in  1  one-cycle pulse; begins (or restarts) a load session
- `ld_valid`  in  1  host has a word on `ld_data`
- `ld_data`  in  WORD_W  host word (length, data or checksum)
- `ld_ready`  out  1  loader accepts a word this cycle
- `cpu_hold`  out  1  high while loading; processor must not fetch/execute
- `load_ok`  out  1  sticky: last session completed with matching checksum
- `load_err`  out  1  sticky: last session completed with checksum mismatch
- `Iaddress`  in  A_W  processor fetch address
- `Idata`  out  WORD_W  instruction at `Iaddress`

## Operation
- A transfer occurs on a rising edge where `ld_valid && ld_ready`. There are no other transfers.
- FSM states are IDLE, LEN, DATA and CHECK.
  - IDLE: `ld_ready=0`. `load_start` moves to LEN, clears `load_ok`/`load_err`, clears the checksum accumulator and sets the write pointer to 0.
  - LEN: `ld_ready=1`. On transfer, `remaining = ld_data[A_W-1:0]`. A value of 0 means 2**A_W words, so `remaining` is A_W+1 bits wide. Upper bits of `ld_data` are ignored. Moves to DATA.
  - DATA: `ld_ready=1`. On transfer, `mem[wptr] <= ld_data`, `csum <= csum ^ ld_data`, `wptr++` and `remaining--`. When `remaining` reaches 0, moves to CHECK.
  - CHECK: `ld_ready=1`. On transfer, sets `load_ok` if `ld_data == csum`, otherwise sets `load_err`, then moves to IDLE.
- The length word and the checksum word are not included in the checksum.
- `wptr` is A_W bits. A 32-word load ends with `wptr` wrapped to 0, which is harmless because DATA has already exited.
- Locations not written in a session keep their previous contents.
- `load_start` in LEN, DATA or CHECK aborts the session and restarts it as from IDLE. Words already written stay written, and no flag is set for the aborted session.
- `load_start` coinciding with a transfer: `load_start` wins and the word is discarded.
- `cpu_hold = (state != IDLE)`, decoded from registered state.
- `Idata`:
  - `= mem[Iaddress]`, combinational, when `cpu_hold=0`.
  - Forced to 0 while `cpu_hold=1`, so the processor sees the same all-zero word an unprogrammed ROM location returns.
- A bad checksum does not roll back memory. It only sets `load_err`, and the host decides whether to reload.

## Timing
- Reset (asynchronous, any time, including mid-load) sets:
  - state = IDLE, so `cpu_hold=0` and `ld_ready=0`
  - `load_ok=0`, `load_err=0`, `wptr=0`, `remaining=0`, `csum=0`
  - every memory word = 0, so `Idata=0` for all addresses
- `ld_ready` rises the cycle after `load_start` is sampled.
- One word can be accepted per cycle. `ld_valid` may drop between words with no penalty.
- A write is visible on `Idata` (once `cpu_hold=0`) in the cycle after the edge that wrote it.
- The flag and `cpu_hold` fall are set on the same edge that accepts the checksum word.
- Minimum session for N data words: N+2 transfer cycles after the cycle in which `ld_ready` rises.

## Test plan
- Reset then idle: with no load, sweep `Iaddress` 0..31 → `Idata=0` everywhere; `ld_ready=0`, `cpu_hold=0`, `load_ok=0`, `load_err=0`.
- Good load with back-to-back words: `load_start`, then 0x03, 0x41, 0x22, 0x07, 0x64 → `load_ok=1`, `load_err=0`; `Idata` = 0x41, 0x22, 0x07 at addresses 0..2 and 0 at address 3; `cpu_hold` high exactly from the cycle after `load_start` through the checksum edge.
- Bad checksum with `ld_valid` gaps of 0–3 cycles: same data, checksum 0x65 → `load_err=1`, `load_ok=0`; memory still holds 0x41, 0x22, 0x07; no word is lost or duplicated.
- Full-depth load: length 0x00, then 32 words of value i+1 → all 32 words written; checksum equals the XOR of 1..32 (0x20) → `load_ok=1`; `Idata[31]=0x20`.
- Restart mid-load: `load_start`, 0x04, 0xAA, 0xBB, then `load_start` again, then 0x01, 0x11, 0x11 → `load_ok=1`; mem[0]=0x11, mem[1]=0xBB.
- Reset mid-load: assert `reset` in DATA after 2 words → next cycle `cpu_hold=0`, `ld_ready=0`, all `Idata=0`, flags 0.
